hello_uart_tx: RTL and testbench
================================

// Module: hello_uart_tx
// PURPOSE
//   Streams the fixed greeting "Hello World\r\n" (13 ASCII bytes) out of a serial
//   line as UART 8N1 frames. Downstream of the greeting source: it turns the
//   simulation-only $display message into a real pin-level transmitter for the
//   board. One i_start pulse sends the whole string once, then the block idles.
// PARAMETERS
//   CLKS_PER_BIT  16  clock cycles per UART bit; legal range 2..65535
//   MSG_LEN       13  bytes in message ROM; fixed to ROM contents, do not override
// PORTS
//   i_clock     in   1  single clock; all state updates on posedge
//   i_reset     in   1  asynchronous, active-high reset
//   i_start     in   1  request to send message; sampled only in IDLE
//   o_tx        out  1  serial line, idle high, registered
//   o_busy      out  1  high from first start bit until o_done cycle (exclusive)
//   o_done      out  1  one-cycle pulse after final stop bit completes
//   o_char_idx  out  4  index (0..12) of byte currently on the line
// BEHAVIOUR
//   - ROM: 0x48 65 6C 6C 6F 20 57 6F 72 6C 64 0D 0A, index 0 first.
//   - Reset values: o_tx=1, o_busy=0, o_done=0, o_char_idx=0, state IDLE,
//     all counters 0. Reset mid-frame aborts at once; o_tx high immediately.
//   - FSM: IDLE -> START -> DATA -> STOP -> (NEXT byte: START | last: IDLE).
//   - IDLE: o_tx=1. i_start=1 at posedge N -> state START, o_busy=1,
//     o_tx=0 from edge N (visible cycle N+1 onward).
//   - Each bit held exactly CLKS_PER_BIT cycles via baud counter
//     (width $clog2(CLKS_PER_BIT)), counting 0..CLKS_PER_BIT-1 then wrapping.
//   - DATA: 8 bits LSB first; 3-bit bit counter wraps 7->0 on leaving DATA.
//   - STOP: o_tx=1 for CLKS_PER_BIT cycles. If o_char_idx<12: increment
//     index, go to START with no idle gap. If o_char_idx==12: go IDLE,
//     o_busy=0, o_done=1 for that one cycle, o_char_idx back to 0.
//   - Total: 13*10*CLKS_PER_BIT cycles from first start-bit cycle to o_done.
//   - i_start while busy: ignored, no queuing, no effect on current frame.
//   - i_start held high through o_done: o_done cycle is IDLE, so i_start
//     sampled there starts a new message; start bit follows next cycle,
//     o_done and o_busy never high in same cycle.
//   - Line never glitches: o_tx driven only from a flop.
// TESTING
//   1 Assert i_reset 3 cycles, i_start=0 -> o_tx=1, o_busy=0, o_done=0,
//     o_char_idx=0; stays so for 100 cycles.
//   2 CLKS_PER_BIT=4, pulse i_start 1 cycle -> bench UART decoder reads exactly
//     48 65 6C 6C 6F 20 57 6F 72 6C 64 0D 0A, all stop bits 1.
//   3 Same run -> o_done pulses once, 520 cycles after first o_tx low cycle;
//     o_busy high exactly those 520 cycles; o_tx=1 afterwards.
//   4 Pulse i_start again at cycle 100 of a message -> output byte stream and
//     o_done timing identical to scenario 3.
//   5 Assert i_reset mid-byte 5 -> o_tx=1, o_busy=0 same cycle; after release
//     and new i_start, full message restarts from 'H' (0x48).
//   6 Hold i_start high for 1200 cycles, CLKS_PER_BIT=4 -> two back-to-back
//     messages, o_done at 520 and 1041 cycles after first start bit.

Source files
------------

// File: rtl/hello_uart_tx.sv
// UART 8N1 transmitter that sends the fixed greeting "Hello World\r\n" once per start request.
// All outputs come straight from flops so the serial line never glitches.
module hello_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MSG_LEN      = 13
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_char_idx
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [3:0]        idx_nxt;
  logic [7:0]        cur_byte;
  logic              tx_nxt, busy_nxt, done_nxt;
  logic              bit_tick;

  assign bit_tick = (baud_cnt == BAUD_LAST);

  function automatic logic [7:0] rom_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_byte = 8'h48;
      4'd1:    rom_byte = 8'h65;
      4'd2:    rom_byte = 8'h6C;
      4'd3:    rom_byte = 8'h6C;
      4'd4:    rom_byte = 8'h6F;
      4'd5:    rom_byte = 8'h20;
      4'd6:    rom_byte = 8'h57;
      4'd7:    rom_byte = 8'h6F;
      4'd8:    rom_byte = 8'h72;
      4'd9:    rom_byte = 8'h6C;
      4'd10:   rom_byte = 8'h64;
      4'd11:   rom_byte = 8'h0D;
      4'd12:   rom_byte = 8'h0A;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  // State, counters and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      o_char_idx <= '0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      o_char_idx <= idx_nxt;
      o_tx       <= tx_nxt;
      o_busy     <= busy_nxt;
      o_done     <= done_nxt;
    end
  end

  // Next state and counter updates
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    idx_nxt   = o_char_idx;
    if (state != IDLE) begin
      baud_nxt = bit_tick ? '0 : baud_cnt + BAUD_W'(1);
    end
    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        idx_nxt  = '0;
        if (i_start) state_nxt = START;
      end
      START: begin
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (o_char_idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            state_nxt = START;
            idx_nxt   = o_char_idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the next cycle, registered above
  always_comb begin
    tx_nxt   = 1'b1;
    cur_byte = rom_byte(idx_nxt);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && bit_tick && (o_char_idx == LAST_IDX);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = cur_byte[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_hello_uart_tx.sv
// Bench for hello_uart_tx: per-cycle comparison against a message-offset model,
// plus a serial decoder that rebuilds the transmitted bytes.
module tb_hello_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;
  localparam int TOTAL = 13 * FRAME;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       tx, busy, done;
  logic [3:0] idx;

  int checks = 0;
  int errors = 0;

  // Model: k = offset from first start-bit cycle, -1 when idle
  int k = -1;
  logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                           8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

  logic [7:0] rx_q [$];
  int         dec_t = -1;
  logic [7:0] dec_sh = '0;

  typedef struct {
    logic       rst;
    logic       start;
    int         n;
    logic       tx;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  hello_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_done     (done),
    .o_char_idx (idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input int kk);
    int bi, pos;
    logic [7:0] m;
    if (kk < 0 || kk >= TOTAL) return 1'b1;
    bi  = kk / FRAME;
    pos = (kk % FRAME) / C;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    m = msg[bi];
    return m[pos-1];
  endfunction

  task automatic step();
    int pos;
    @(posedge clk);
    if (rst) k = -1;
    else if (k < 0 || k >= TOTAL) k = start ? 0 : -1;
    else k++;
    #1;
    chk("tx", 32'(tx), 32'(exp_tx(k)));
    chk("busy", 32'(busy), (k >= 0 && k < TOTAL) ? 32'd1 : 32'd0);
    chk("done", 32'(done), (k == TOTAL) ? 32'd1 : 32'd0);
    chk("char_idx", 32'(idx), (k >= 0 && k < TOTAL) ? 32'(k / FRAME) : 32'd0);
    // Mid-bit sampling decoder
    if (rst) dec_t = -1;
    else if (dec_t < 0) begin
      if (tx === 1'b0) dec_t = 0;
    end else dec_t++;
    if (dec_t >= 0 && (dec_t % C) == C / 2) begin
      pos = dec_t / C;
      if (pos >= 1 && pos <= 8) dec_sh[pos-1] = tx;
      if (pos == 9) begin
        chk("stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(dec_sh);
        dec_t = -1;
      end
    end
  endtask

  initial begin
    int done_at, busy_cnt, p;

    tbl[0]  = '{1'b1, 1'b0,    3, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0,  100, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1,    1, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 1'b0,   99, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[4]  = '{1'b0, 1'b1,    1, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[5]  = '{1'b0, 1'b0,  419, 1'b1, 1'b1, 1'b0, 4'd12};
    tbl[6]  = '{1'b0, 1'b0,    1, 1'b1, 1'b0, 1'b1, 4'd0};
    tbl[7]  = '{1'b0, 1'b0,    1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 1'b1, 1041, 1'b1, 1'b1, 1'b0, 4'd12};
    tbl[9]  = '{1'b0, 1'b0,    1, 1'b1, 1'b0, 1'b1, 4'd0};
    tbl[10] = '{1'b0, 1'b0,    5, 1'b1, 1'b0, 1'b0, 4'd0};

    rx_q.delete();
    for (int i = 0; i < 11; i++) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d_tx", i), 32'(tx), 32'(tbl[i].tx));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(tbl[i].idx));
    end
    // Restart pulse ignored, then two held-start messages: 39 bytes total
    chk("rx_count", 32'(rx_q.size()), 32'd39);
    for (int i = 0; i < rx_q.size() && i < 39; i++)
      chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(msg[i % 13]));

    // Single message: done timing and busy width
    rx_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_start_bit", 32'(tx), 32'd0);
    done_at  = -1;
    busy_cnt = busy ? 1 : 0;
    for (int c = 1; c < 2000 && done_at < 0; c++) begin
      step();
      if (busy) busy_cnt++;
      if (done) done_at = c;
    end
    chk("done_offset", 32'(done_at), 32'(TOTAL));
    chk("busy_cycles", 32'(busy_cnt), 32'(TOTAL));
    chk("msg_bytes", 32'(rx_q.size()), 32'd13);
    repeat (3) step();
    chk("idle_after", 32'(tx), 32'd1);

    // Reset in the middle of byte 5 takes effect before the next edge
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5 * FRAME + 10 - 1) step();
    chk("mid_byte5_idx", 32'(idx), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_idx", 32'(idx), 32'd0);
    dec_t = -1;
    repeat (2) step();
    rst = 1'b0;
    step();
    rx_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (FRAME + 10) step();
    chk("restart_count", 32'(rx_q.size()), 32'd1);
    chk("restart_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h48);

    // Random start/reset traffic against the model
    for (int r = 0; r < 30; r++) begin
      p = $urandom_range(0, 20);
      repeat ($urandom_range(1, 600)) begin
        start = ($urandom_range(0, 99) < p);
        rst   = ($urandom_range(0, 1999) == 0);
        step();
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (TOTAL + 5) step();
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
